// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result queues arbitrated onto a registered common data bus.
// Define CDB_ROUND_ROBIN_EN for round-robin grant; otherwise lowest-index queue wins.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter #(
  parameter int NUM_FU      = 4,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_FU-1:0]               fu_valid,
  input  logic [NUM_FU*`ROB_TAG_LEN-1:0]  fu_rob_tag,
  input  logic [NUM_FU*32-1:0]            fu_value,
  output logic [NUM_FU-1:0]               fu_stall,
  input  logic                            flush,
  output logic [`ROB_TAG_LEN+32:0]        cdb
);

  localparam int TAG_W = `ROB_TAG_LEN;
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [TAG_W-1:0] q_tag [NUM_FU][QUEUE_DEPTH];
  logic [31:0]      q_val [NUM_FU][QUEUE_DEPTH];
  logic [PTR_W-1:0] head  [NUM_FU];
  logic [PTR_W-1:0] tail  [NUM_FU];
  logic [CNT_W-1:0] count [NUM_FU];

  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              grant_any;
  logic [IDX_W-1:0]  grant_idx;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  assign cdb = {cdb_valid, cdb_tag, cdb_value};

  always_comb begin
    nonempty = '0;
    fu_stall = '0;
    push     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      nonempty[i] = (count[i] != '0);
      fu_stall[i] = (count[i] == CNT_W'(QUEUE_DEPTH));
      // Tag 0 means "no producer", so such results are silently dropped.
      push[i] = fu_valid[i] && !fu_stall[i] && !flush &&
                (fu_rob_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int j;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_FU) j = j - NUM_FU;
      if (!grant_any && nonempty[j]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (!flush && grant_any) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (nonempty[i]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i] = grant_any && !flush && (grant_idx == IDX_W'(i));
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        q_tag[i][tail[i]] <= fu_rob_tag[i*TAG_W +: TAG_W];
        q_val[i][tail[i]] <= fu_value[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) tail[i] <= tail[i] + 1'b1;
        if (pop[i])  head[i] <= head[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (grant_any) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= q_tag[grant_idx][head[grant_idx]];
      cdb_value <= q_val[grant_idx][head[grant_idx]];
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed checks of cdb_arbiter against a queue-based model.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_cdb_arbiter;

  localparam int NUM_FU = 4;
  localparam int DEPTH  = 2;
  localparam int TAG_W  = `ROB_TAG_LEN;

  logic                      clk;
  logic                      reset;
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU*TAG_W-1:0]   fu_rob_tag;
  logic [NUM_FU*32-1:0]      fu_value;
  logic [NUM_FU-1:0]         fu_stall;
  logic                      flush;
  logic [TAG_W+32:0]         cdb;

  cdb_arbiter #(.NUM_FU(NUM_FU), .QUEUE_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .fu_valid   (fu_valid),
    .fu_rob_tag (fu_rob_tag),
    .fu_value   (fu_value),
    .fu_stall   (fu_stall),
    .flush      (flush),
    .cdb        (cdb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [TAG_W-1:0] m_tag [NUM_FU][$];
  logic [31:0]      m_val [NUM_FU][$];
  logic             exp_valid;
  logic [TAG_W-1:0] exp_tag;
  logic [31:0]      exp_val;
  int               exp_rr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_FU-1:0] model_stall();
    logic [NUM_FU-1:0] s;
    for (int i = 0; i < NUM_FU; i++) s[i] = (m_tag[i].size() == DEPTH);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      m_tag[i].delete();
      m_val[i].delete();
    end
    exp_valid = 1'b0;
    exp_tag   = '0;
    exp_val   = '0;
    exp_rr    = 0;
  endtask

  // Applies one clock edge's worth of arbitration rules to the model queues.
  task automatic model_edge();
    logic [NUM_FU-1:0] full;
    int g;
    full = model_stall();
    if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        m_tag[i].delete();
        m_val[i].delete();
      end
      exp_valid = 1'b0;
    end else begin
      g = -1;
`ifdef CDB_ROUND_ROBIN_EN
      for (int k = 0; k < NUM_FU; k++)
        if (g < 0 && m_tag[(exp_rr + k) % NUM_FU].size() > 0) g = (exp_rr + k) % NUM_FU;
`else
      for (int i = 0; i < NUM_FU; i++)
        if (g < 0 && m_tag[i].size() > 0) g = i;
`endif
      if (g >= 0) begin
        exp_valid = 1'b1;
        exp_tag   = m_tag[g].pop_front();
        exp_val   = m_val[g].pop_front();
        exp_rr    = (g + 1) % NUM_FU;
      end else begin
        exp_valid = 1'b0;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && !full[i] && fu_rob_tag[i*TAG_W +: TAG_W] != '0) begin
          m_tag[i].push_back(fu_rob_tag[i*TAG_W +: TAG_W]);
          m_val[i].push_back(fu_value[i*32 +: 32]);
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("cdb_valid", 64'(cdb[TAG_W+32]), 64'(exp_valid));
    check_eq("cdb_tag",   64'(cdb[TAG_W+31:32]), 64'(exp_tag));
    check_eq("cdb_value", 64'(cdb[31:0]), 64'(exp_val));
    check_eq("fu_stall",  64'(fu_stall), 64'(model_stall()));
  endtask

  task automatic clear_inputs();
    fu_valid   = '0;
    fu_rob_tag = '0;
    fu_value   = '0;
    flush      = 1'b0;
  endtask

  task automatic drive(input int i, input logic [TAG_W-1:0] t, input logic [31:0] v);
    fu_valid[i] = 1'b1;
    fu_rob_tag[i*TAG_W +: TAG_W] = t;
    fu_value[i*32 +: 32] = v;
  endtask

  initial begin
    int fu1_idx;
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #2;
    check_eq("reset_cdb", 64'(cdb), 64'd0);
    check_eq("reset_stall", 64'(fu_stall), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single result latency and one-cycle valid.
    drive(1, 5, 32'hDEAD_BEEF);
    step();
    check_eq("single_push_no_cdb", 64'(cdb[TAG_W+32]), 64'd0);
    clear_inputs();
    step();
    check_eq("single_tag", 64'(cdb[TAG_W+31:32]), 64'd5);
    check_eq("single_value", 64'(cdb[31:0]), 64'hDEAD_BEEF);
    step();
    check_eq("single_drop", 64'(cdb[TAG_W+32]), 64'd0);

    // All four FUs contend at once.
    for (int i = 0; i < NUM_FU; i++) drive(i, TAG_W'(i + 1), 32'h100 + i);
    step();
    clear_inputs();
    repeat (5) step();

    // FU0 back-to-back while FU3 waits.
    drive(0, 10, 32'hA0);
    drive(3, 20, 32'hB0);
    step();
    clear_inputs();
    drive(0, 11, 32'hA1);
    step();
    clear_inputs();
    repeat (4) step();

    // FU0 saturates the bus while FU1 holds results across stalls.
    fu1_idx = 0;
    for (int c = 0; c < 12; c++) begin
      clear_inputs();
      drive(0, TAG_W'(30 + c), 32'hC00 + c);
      if (fu1_idx < 3) drive(1, TAG_W'(21 + fu1_idx), 32'hD00 + fu1_idx);
      if (fu1_idx < 3 && !fu_stall[1]) fu1_idx++;
      step();
    end
    clear_inputs();
    repeat (16) step();

    // Flush with queued results and a same-cycle push.
    drive(0, 7, 32'h7);
    drive(1, 8, 32'h8);
    drive(2, 9, 32'h9);
    step();
    clear_inputs();
    flush = 1'b1;
    drive(3, 12, 32'hC);
    step();
    check_eq("flush_valid", 64'(cdb[TAG_W+32]), 64'd0);
    check_eq("flush_stall", 64'(fu_stall), 64'd0);
    clear_inputs();
    repeat (4) step();

    // Tag zero is ignored.
    for (int i = 0; i < NUM_FU; i++) drive(i, '0, 32'hFFFF_0000 + i);
    step();
    clear_inputs();
    repeat (2) step();

    // Asynchronous reset with two results queued.
    drive(2, 14, 32'hE);
    drive(3, 15, 32'hF);
    step();
    clear_inputs();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("midreset_valid", 64'(cdb[TAG_W+32]), 64'd0);
    check_eq("midreset_stall", 64'(fu_stall), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) step();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      for (int i = 0; i < NUM_FU; i++) begin
        if ($urandom_range(0, 99) < 55) begin
          drive(i, ($urandom_range(0, 7) == 0) ? '0 : TAG_W'($urandom_range(1, (1 << TAG_W) - 1)),
                $urandom());
        end
      end
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    clear_inputs();
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
